player_ctrl: RTL and testbench
==============================

// Module: player_ctrl
// PURPOSE
//  Parametrised player-ship controller; successor to the single-ship mover.
//  Decodes NUM_KEYS USB keycode slots into clamped per-frame motion, rate-limited fire pulses,
//  hit/life bookkeeping with grace window, and a timed powerup mode FSM. Feeds sprite draw,
//  projectile spawner (shoot) and score/HUD logic (lives, score_mult, game_over).
// PARAMETERS
//  NUM_KEYS   3    keycode slots on keycodes bus
//  SIZE       30   ship half-size (px); also driven on ship_s
//  MARGIN     12   extra edge keep-out (px)
//  X_CENTER   305  reset X;  Y_CENTER 320 reset Y
//  X_MAX      639  screen right edge;  Y_MAX 479 screen bottom edge (min edges are 0)
//  SLOW_STEP  1    step in SHIELD;  STEP 3 normal/DOUBLE;  FAST_STEP 6 in SPEED
//  PU_FRAMES  511  frames a powerup mode lasts (>=1)
//  SHOOT_CD   16   min frames between shoot pulses (>=1)
//  HIT_GRACE  63   frames of post-hit immunity
//  LIVES      3    starting lives (LIFE_W = $clog2(LIVES+1))
// PORTS
//  frame_clk    in   1            sole clock, one edge per video frame
//  Reset        in   1            synchronous, active-high
//  keycodes     in   8*NUM_KEYS   slot k = [8k+7:8k]; A=04 D=07 S=16 W=1A SPACE=2C
//  hit          in   1            collision this frame
//  powerup      in   1            powerup collected this frame; type by next three
//  speedup, invincible, doublescore  in 1 each  powerup type qualifiers
//  ship_x, ship_y  out 10         ship centre
//  ship_s       out  10           = SIZE constant
//  shoot        out  1            one-frame fire pulse
//  lose_life    out  1            one-frame life-lost pulse
//  lives        out  LIFE_W       remaining lives
//  game_over    out  1            lives == 0 (registered)
//  mode         out  2            0 NORMAL,1 SPEED,2 SHIELD,3 DOUBLE
//  score_mult   out  2            2 in DOUBLE else 1
//  ship_r/g/b   out  8 each       NORMAL ff/00/00, SPEED 00/00/ff, SHIELD 00/ff/00, DOUBLE ff/ff/00
// BEHAVIOUR
//  All state updates on posedge frame_clk; Reset synchronous, active-high, wins over all inputs.
//  Reset values: ship_x=X_CENTER, ship_y=Y_CENTER, shoot=0, lose_life=0, lives=LIVES, game_over=0,
//   mode=NORMAL, score_mult=1, colour ff/00/00; pu timer, cooldown, grace, last-fire all 0.
//  Key decode: a key is pressed if ANY slot equals its code (OR over NUM_KEYS).
//  Mode FSM: powerup=1 -> mode by priority speedup>invincible>doublescore, timer<=PU_FRAMES-1;
//   powerup with no qualifier ignored. A new powerup while active replaces mode and reloads.
//   Otherwise timer!=0 -> timer-1; timer==0 and mode!=NORMAL -> NORMAL. Mode held PU_FRAMES frames.
//  Step = f(registered mode). Position updates directly (no motion-register lag):
//   A xor D drives X; A and D together -> no X motion; same for W/S on Y.
//   Limits: X in [SIZE+MARGIN, X_MAX-SIZE-MARGIN], Y in [SIZE+MARGIN, Y_MAX-SIZE-MARGIN];
//   a step that would cross a limit lands exactly on it (no underflow; compare x < lo+step).
//  Fire: cooldown loaded SHOOT_CD-1 on pulse, decrements to 0. Pulse when cooldown==0 and trigger.
//  Hit: hit & grace==0 & mode!=SHIELD & lives!=0 -> lose_life=1, lives-1, grace<=HIT_GRACE;
//   grace decrements to 0 otherwise (also during SHIELD). lives saturates at 0.
//  game_over set the frame lives becomes 0; then position frozen, shoot=0, lose_life=0,
//   powerups ignored; only Reset clears it.
//  Outputs registered; score_mult and colour track registered mode same cycle.
// CONFIGURATION
//  AUTOFIRE_EN defined: trigger = SPACE held; pulses every SHOOT_CD frames while held.
//  AUTOFIRE_EN undefined: trigger = SPACE rising edge (pressed now, not last frame); holding
//   gives one pulse; re-press inside cooldown is dropped, not queued.
// TESTING
//  Reset, hold D (slot 2=07) 200 frames -> ship_x rises by 3/frame, stops exactly at 597.
//  A and D in slots 0/1 same frame -> ship_x unchanged; W alone from y=42 -> clamps at 42.
//  powerup+speedup -> mode=1, step 6, colour 00/00/ff for 511 frames, then mode=0 step 3.
//  powerup+invincible then hit every frame -> no lose_life; after expiry, first hit pulses once,
//   lives 3->2, next pulse no earlier than 64 frames later.
//  Three spaced hits -> lives=0, game_over=1, keys ignored; Reset -> lives=3, centred.
//  SPACE held 40 frames: AUTOFIRE_EN -> pulses at frames 0,16,32; without -> single pulse.

Source files
------------

// File: rtl/player_ctrl_if.sv
// player_ctrl_if: keycode/event inputs and ship state outputs of the player controller
interface player_ctrl_if #(
  parameter int NUM_KEYS = 3,
  parameter int LIFE_W   = 2
);
  logic [8*NUM_KEYS-1:0] keycodes;
  logic                  hit;
  logic                  powerup;
  logic                  speedup;
  logic                  invincible;
  logic                  doublescore;
  logic [9:0]            ship_x;
  logic [9:0]            ship_y;
  logic [9:0]            ship_s;
  logic                  shoot;
  logic                  lose_life;
  logic [LIFE_W-1:0]     lives;
  logic                  game_over;
  logic [1:0]            mode;
  logic [1:0]            score_mult;
  logic [7:0]            ship_r;
  logic [7:0]            ship_g;
  logic [7:0]            ship_b;
  modport master (
    output keycodes, hit, powerup, speedup, invincible, doublescore,
    input  ship_x, ship_y, ship_s, shoot, lose_life, lives, game_over, mode, score_mult,
           ship_r, ship_g, ship_b
  );
  modport slave (
    input  keycodes, hit, powerup, speedup, invincible, doublescore,
    output ship_x, ship_y, ship_s, shoot, lose_life, lives, game_over, mode, score_mult,
           ship_r, ship_g, ship_b
  );
endinterface

// File: rtl/player_ctrl.sv
// player_ctrl: per-frame ship motion, fire rate limit, lives/grace and powerup mode FSM (AUTOFIRE_EN selects held-trigger fire)
module player_ctrl #(
  parameter int NUM_KEYS  = 3,
  parameter int SIZE      = 30,
  parameter int MARGIN    = 12,
  parameter int X_CENTER  = 305,
  parameter int Y_CENTER  = 320,
  parameter int X_MAX     = 639,
  parameter int Y_MAX     = 479,
  parameter int SLOW_STEP = 1,
  parameter int STEP      = 3,
  parameter int FAST_STEP = 6,
  parameter int PU_FRAMES = 511,
  parameter int SHOOT_CD  = 16,
  parameter int HIT_GRACE = 63,
  parameter int LIVES     = 3
) (
  input logic       frame_clk,
  input logic       Reset,
  player_ctrl_if.slave bus
);
  localparam int LIFE_W = $clog2(LIVES + 1);
  localparam int TW = $clog2(PU_FRAMES + 1);
  localparam int CW = $clog2(SHOOT_CD + 1);
  localparam int GW = $clog2(HIT_GRACE + 2);
  localparam logic [9:0] X_LO = 10'(SIZE + MARGIN);
  localparam logic [9:0] X_HI = 10'(X_MAX - SIZE - MARGIN);
  localparam logic [9:0] Y_LO = 10'(SIZE + MARGIN);
  localparam logic [9:0] Y_HI = 10'(Y_MAX - SIZE - MARGIN);
  typedef enum logic [1:0] {NORMAL, SPEED, SHIELD, DOUBLE} mode_e;
  mode_e             mode_q, mode_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [9:0]        x_q, x_d, y_q, y_d, stp;
  logic [CW-1:0]     cd_q, cd_d;
  logic [GW-1:0]     gr_q, gr_d;
  logic [LIFE_W-1:0] lives_q, lives_d;
  logic              shoot_q, shoot_d, lose_q, lose_d, go_q, go_d;
  logic              ka, kd, kw, ks, ksp, trig;
  // a key counts as pressed when any slot carries its code
  always_comb begin
    ka = 1'b0;
    kd = 1'b0;
    kw = 1'b0;
    ks = 1'b0;
    ksp = 1'b0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      ka  = ka  | (bus.keycodes[8*k +: 8] == 8'h04);
      kd  = kd  | (bus.keycodes[8*k +: 8] == 8'h07);
      ks  = ks  | (bus.keycodes[8*k +: 8] == 8'h16);
      kw  = kw  | (bus.keycodes[8*k +: 8] == 8'h1A);
      ksp = ksp | (bus.keycodes[8*k +: 8] == 8'h2C);
    end
  end
  // powerup mode FSM: qualified powerup (re)loads the timer, expiry returns to NORMAL
  always_comb begin
    mode_d = mode_q;
    tmr_d = tmr_q;
    if (bus.powerup && !go_q && (bus.speedup || bus.invincible || bus.doublescore)) begin
      mode_d = bus.speedup ? SPEED : bus.invincible ? SHIELD : DOUBLE;
      tmr_d = TW'(PU_FRAMES - 1);
    end else if (tmr_q != '0) tmr_d = tmr_q - TW'(1);
    else mode_d = NORMAL;
  end
  // clamped motion; opposing keys cancel, frozen after game over
  always_comb begin
    stp = mode_q == SHIELD ? 10'(SLOW_STEP) : mode_q == SPEED ? 10'(FAST_STEP) : 10'(STEP);
    x_d = go_q ? x_q
        : (kd && !ka) ? ((x_q + stp > X_HI) ? X_HI : x_q + stp)
        : (ka && !kd) ? ((x_q < X_LO + stp) ? X_LO : x_q - stp)
        : x_q;
    y_d = go_q ? y_q
        : (ks && !kw) ? ((y_q + stp > Y_HI) ? Y_HI : y_q + stp)
        : (kw && !ks) ? ((y_q < Y_LO + stp) ? Y_LO : y_q - stp)
        : y_q;
  end
`ifdef AUTOFIRE_EN
  assign trig = ksp;
`else
  logic spc_q;
  // remember last frame's SPACE so only a fresh press triggers
  always_ff @(posedge frame_clk) begin
    if (Reset) spc_q <= 1'b0;
    else spc_q <= ksp;
  end
  assign trig = ksp & ~spc_q;
`endif
  // fire cooldown and hit/grace/lives bookkeeping
  always_comb begin
    shoot_d = !go_q && cd_q == '0 && trig;
    cd_d = shoot_d ? CW'(SHOOT_CD - 1) : (cd_q != '0) ? cd_q - CW'(1) : cd_q;
    lose_d = bus.hit && gr_q == '0 && mode_q != SHIELD && lives_q != '0 && !go_q;
    lives_d = lose_d ? lives_q - LIFE_W'(1) : lives_q;
    gr_d = lose_d ? GW'(HIT_GRACE) : (gr_q != '0) ? gr_q - GW'(1) : gr_q;
    go_d = go_q | (lose_d && lives_q == LIFE_W'(1));
  end
  // state registers
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      mode_q  <= NORMAL;
      tmr_q   <= '0;
      x_q     <= 10'(X_CENTER);
      y_q     <= 10'(Y_CENTER);
      cd_q    <= '0;
      gr_q    <= '0;
      lives_q <= LIFE_W'(LIVES);
      shoot_q <= 1'b0;
      lose_q  <= 1'b0;
      go_q    <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      tmr_q   <= tmr_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cd_q    <= cd_d;
      gr_q    <= gr_d;
      lives_q <= lives_d;
      shoot_q <= shoot_d;
      lose_q  <= lose_d;
      go_q    <= go_d;
    end
  end
  assign bus.ship_x     = x_q;
  assign bus.ship_y     = y_q;
  assign bus.ship_s     = 10'(SIZE);
  assign bus.shoot      = shoot_q;
  assign bus.lose_life  = lose_q;
  assign bus.lives      = lives_q;
  assign bus.game_over  = go_q;
  assign bus.mode       = mode_q;
  assign bus.score_mult = mode_q == DOUBLE ? 2'd2 : 2'd1;
  assign bus.ship_r     = (mode_q == NORMAL || mode_q == DOUBLE) ? 8'hff : 8'h00;
  assign bus.ship_g     = (mode_q == SHIELD || mode_q == DOUBLE) ? 8'hff : 8'h00;
  assign bus.ship_b     = mode_q == SPEED ? 8'hff : 8'h00;
endmodule

// File: tb/tb_player_ctrl.sv
// tb_player_ctrl: directed frames with queued expectations checked by a negedge monitor
module tb_player_ctrl;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_run = 0;
  int   n_fail = 0;
  int   c0;
  typedef struct {int cyc; int sel; int val; string nm;} ent_t;
  ent_t exp_q[$];
  int   sh_q[$];
  int   ll_q[$];

  player_ctrl_if #(.NUM_KEYS(3), .LIFE_W(2)) bus ();
  player_ctrl dut (.frame_clk(clk), .Reset(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get(int sel);
    case (sel)
      0: return int'(bus.ship_x);
      1: return int'(bus.ship_y);
      2: return int'(bus.lives);
      3: return int'(bus.game_over);
      4: return int'(bus.mode);
      5: return int'(bus.score_mult);
      6: return int'({bus.ship_r, bus.ship_g, bus.ship_b});
      default: return int'(bus.ship_s);
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input int sel, input int val, input string nm);
    ent_t e;
    e.cyc = cyc;
    e.sel = sel;
    e.val = val;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    ent_t e;
    int a;
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      a = get(e.sel);
      n_run++;
      if (a != e.val || e.cyc != cyc) begin
        n_fail++;
        $display("FAIL %s frame %0d: got %0d (0x%0h) expected %0d (0x%0h)", e.nm, cyc, a, a, e.val, e.val);
      end
    end
    while (sh_q.size() > 0 && sh_q[0] < cyc) begin
      n_run++;
      n_fail++;
      $display("FAIL shoot_missing: no pulse at frame %0d (now %0d)", sh_q[0], cyc);
      void'(sh_q.pop_front());
    end
    if (bus.shoot === 1'b1) begin
      n_run++;
      if (sh_q.size() > 0 && sh_q[0] == cyc) void'(sh_q.pop_front());
      else begin
        n_fail++;
        $display("FAIL shoot_unexpected: got pulse at frame %0d, expected %0d", cyc, sh_q.size() > 0 ? sh_q[0] : -1);
      end
    end
    while (ll_q.size() > 0 && ll_q[0] < cyc) begin
      n_run++;
      n_fail++;
      $display("FAIL lose_missing: no pulse at frame %0d (now %0d)", ll_q[0], cyc);
      void'(ll_q.pop_front());
    end
    if (bus.lose_life === 1'b1) begin
      n_run++;
      if (ll_q.size() > 0 && ll_q[0] == cyc) void'(ll_q.pop_front());
      else begin
        n_fail++;
        $display("FAIL lose_unexpected: got pulse at frame %0d, expected %0d", cyc, ll_q.size() > 0 ? ll_q[0] : -1);
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.keycodes = '0;
    bus.hit = 1'b0;
    bus.powerup = 1'b0;
    bus.speedup = 1'b0;
    bus.invincible = 1'b0;
    bus.doublescore = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk(0, 305, "rst_x");
    chk(1, 320, "rst_y");
    chk(2, 3, "rst_lives");
    chk(3, 0, "rst_go");
    chk(4, 0, "rst_mode");
    chk(5, 1, "rst_mult");
    chk(6, 24'hff0000, "rst_rgb");
    chk(7, 30, "ship_s");
    bus.keycodes = {8'h07, 16'h0};
    for (int i = 1; i <= 200; i++) begin
      tick();
      chk(0, (305 + 3 * i > 597) ? 597 : 305 + 3 * i, "hold_d_x");
    end
    bus.keycodes = {8'h00, 8'h07, 8'h04};
    tick();
    chk(0, 597, "a_and_d_x");
    chk(1, 320, "a_and_d_y");
    bus.keycodes = {16'h0, 8'h1A};
    for (int i = 1; i <= 100; i++) begin
      tick();
      chk(1, (320 - 3 * i < 42) ? 42 : 320 - 3 * i, "hold_w_y");
    end
    tick();
    chk(1, 42, "w_clamp_y");
    bus.keycodes = '0;
    bus.powerup = 1'b1;
    bus.speedup = 1'b1;
    tick();
    bus.powerup = 1'b0;
    bus.speedup = 1'b0;
    c0 = cyc;
    chk(4, 1, "speed_mode");
    chk(6, 24'h0000ff, "speed_rgb");
    chk(5, 1, "speed_mult");
    bus.keycodes = {16'h0, 8'h16};
    repeat (10) tick();
    chk(1, 102, "speed_step_y");
    bus.keycodes = '0;
    while (cyc < c0 + 510) tick();
    chk(4, 1, "speed_last_frame");
    tick();
    chk(4, 0, "speed_expired");
    chk(6, 24'hff0000, "normal_rgb");
    bus.keycodes = {16'h0, 8'h16};
    tick();
    chk(1, 105, "normal_step_y");
    bus.keycodes = '0;
    bus.powerup = 1'b1;
    bus.doublescore = 1'b1;
    tick();
    chk(4, 3, "double_mode");
    chk(5, 2, "double_mult");
    chk(6, 24'hffff00, "double_rgb");
    bus.speedup = 1'b1;
    bus.invincible = 1'b1;
    tick();
    chk(4, 1, "prio_replace_mode");
    chk(5, 1, "prio_replace_mult");
    bus.speedup = 1'b0;
    bus.invincible = 1'b0;
    bus.doublescore = 1'b0;
    tick();
    chk(4, 1, "no_qualifier_ignored");
    bus.powerup = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(4, 0, "rst2_mode");
    bus.powerup = 1'b1;
    bus.invincible = 1'b1;
    tick();
    bus.powerup = 1'b0;
    bus.invincible = 1'b0;
    bus.hit = 1'b1;
    c0 = cyc;
    chk(4, 2, "shield_mode");
    chk(6, 24'h00ff00, "shield_rgb");
    ll_q.push_back(c0 + 512);
    ll_q.push_back(c0 + 576);
    while (cyc < c0 + 511) tick();
    chk(2, 3, "shield_lives");
    while (cyc < c0 + 512) tick();
    chk(2, 2, "first_hit_lives");
    chk(4, 0, "shield_expired");
    while (cyc < c0 + 575) tick();
    chk(2, 2, "grace_lives");
    tick();
    bus.hit = 1'b0;
    chk(2, 1, "second_hit_lives");
    repeat (70) tick();
    bus.hit = 1'b1;
    ll_q.push_back(cyc + 1);
    tick();
    bus.hit = 1'b0;
    chk(2, 0, "third_hit_lives");
    chk(3, 1, "game_over_set");
    bus.keycodes = {8'h07, 8'h1A, 8'h2C};
    bus.powerup = 1'b1;
    bus.speedup = 1'b1;
    bus.hit = 1'b1;
    repeat (5) tick();
    chk(0, 305, "go_frozen_x");
    chk(1, 320, "go_frozen_y");
    chk(4, 0, "go_powerup_ignored");
    chk(2, 0, "go_lives");
    chk(3, 1, "go_held");
    bus.keycodes = '0;
    bus.powerup = 1'b0;
    bus.speedup = 1'b0;
    bus.hit = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk(2, 3, "rst3_lives");
    chk(3, 0, "rst3_go");
    chk(0, 305, "rst3_x");
    chk(1, 320, "rst3_y");
    bus.keycodes = {16'h0, 8'h2C};
    sh_q.push_back(cyc + 1);
`ifdef AUTOFIRE_EN
    sh_q.push_back(cyc + 17);
    sh_q.push_back(cyc + 33);
`endif
    repeat (40) tick();
    bus.keycodes = '0;
    repeat (20) tick();
    bus.keycodes = {16'h0, 8'h2C};
    sh_q.push_back(cyc + 1);
    tick();
    bus.keycodes = '0;
    tick();
    bus.keycodes = {16'h0, 8'h2C};
    repeat (10) tick();
    bus.keycodes = '0;
    repeat (10) tick();
    bus.keycodes = {8'h2C, 16'h0};
    sh_q.push_back(cyc + 1);
    tick();
    bus.keycodes = '0;
    repeat (20) tick();
    @(negedge clk);
    #1;
    while (sh_q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL shoot_missing: no pulse at frame %0d", sh_q.pop_front());
    end
    while (ll_q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL lose_missing: no pulse at frame %0d", ll_q.pop_front());
    end
    while (exp_q.size() > 0) begin
      n_run++;
      n_fail++;
      $display("FAIL unchecked %s: got none expected %0d", exp_q[0].nm, exp_q[0].val);
      void'(exp_q.pop_front());
    end
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
